// File: rtl/mario_input_ctrl.sv
// rtl/mario_input_ctrl.sv - frame-aligned key conditioning and jump FSM for Mario physics
//
// Purpose:
//   Turns the raw USB keycode into per-frame movement levels and a jump
//   control pair (one-shot start, variable-length hold) for the physics stage.
//   Also generates the frame tick from VGA vertical sync.
//
// Ports:
//   Clk        in   50 MHz clock
//   Reset_n    in   synchronous active-low reset
//   frame_vs   in   raw VGA vsync, active low (async to nothing, but resynced)
//   keycode    in   current USB keycode, 8'h00 = no key
//   grounded   in   Mario standing on a surface
//   frame_tick out  one-cycle pulse at the end of each vsync pulse
//   left       out  left key held, latched once per frame
//   right      out  right key held, latched once per frame
//   down       out  down key held, latched once per frame
//   jump_start out  one-cycle pulse when a jump begins
//   jump_hold  out  high while the jump is in its rising/hold phase
//   hold_cnt   out  frames elapsed in the current hold phase
//
// Optional feature macro: KEY_STABLE_FILTER_EN
//   When defined, a key change is only accepted after the same keycode has
//   been sampled on two consecutive frame ticks (single-frame glitch reject).

module mario_input_ctrl #(
  parameter logic [7:0] LEFT_CODE  = 8'h04,
  parameter logic [7:0] RIGHT_CODE = 8'h07,
  parameter logic [7:0] JUMP_CODE  = 8'h1A,
  parameter logic [7:0] DOWN_CODE  = 8'h16,
  parameter int         MAX_HOLD   = 12,
  parameter int         HOLD_W     = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_vs,
  input  logic [7:0]        keycode,
  input  logic              grounded,
  output logic              frame_tick,
  output logic              left,
  output logic              right,
  output logic              down,
  output logic              jump_start,
  output logic              jump_hold,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RISE = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // VS synchronizer (s1, s2) and edge register (s3)
  logic              vs_s1_q, vs_s1_d;
  logic              vs_s2_q, vs_s2_d;
  logic              vs_s3_q, vs_s3_d;
  logic              frame_tick_q, frame_tick_d;
  // frame_tick delayed by one cycle so the FSM sees the freshly latched key
  logic              tick_dly_q, tick_dly_d;
  logic [7:0]        key_q, key_d;
`ifdef KEY_STABLE_FILTER_EN
  logic [7:0]        key_prev_q, key_prev_d;
`endif
  logic              left_q, left_d;
  logic              right_q, right_d;
  logic              down_q, down_d;
  logic [1:0]        state_q, state_d;
  logic              jump_start_q, jump_start_d;
  logic              jump_hold_q, jump_hold_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              jump_key;

  always_comb begin
    vs_s1_d = frame_vs;
    vs_s2_d = vs_s1_q;
    vs_s3_d = vs_s2_q;
    // Rising edge of synced VS = end of the vsync pulse
    frame_tick_d = vs_s2_q & ~vs_s3_q;
    tick_dly_d   = frame_tick_q;

    key_d = key_q;
`ifdef KEY_STABLE_FILTER_EN
    key_prev_d = key_prev_q;
    if (frame_tick_q) begin
      key_prev_d = keycode;
      if (keycode == key_prev_q) begin
        key_d = keycode;
      end
    end
`else
    if (frame_tick_q) begin
      key_d = keycode;
    end
`endif

    // Decoding the next key value lets the direction outputs update in the
    // same cycle as key_q, one cycle after frame_tick.
    left_d  = (key_d == LEFT_CODE);
    right_d = (key_d == RIGHT_CODE);
    down_d  = (key_d == DOWN_CODE);

    jump_key     = (key_q == JUMP_CODE);
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    jump_start_d = 1'b0;

    if (tick_dly_q) begin
      case (state_q)
        IDLE: begin
          if (jump_key && grounded) begin
            state_d      = RISE;
            hold_cnt_d   = '0;
            jump_start_d = 1'b1;
          end
        end
        RISE: begin
          // grounded is deliberately ignored while rising
          if (jump_key && (hold_cnt_q < HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end else begin
            state_d = LOCK;
          end
        end
        LOCK: begin
          // Key must be released before another jump can start
          if (!jump_key && grounded) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    jump_hold_d = (state_d == RISE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_s1_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      vs_s3_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      tick_dly_q   <= 1'b0;
      key_q        <= 8'h00;
`ifdef KEY_STABLE_FILTER_EN
      key_prev_q   <= 8'h00;
`endif
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      down_q       <= 1'b0;
      state_q      <= IDLE;
      jump_start_q <= 1'b0;
      jump_hold_q  <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      vs_s1_q      <= vs_s1_d;
      vs_s2_q      <= vs_s2_d;
      vs_s3_q      <= vs_s3_d;
      frame_tick_q <= frame_tick_d;
      tick_dly_q   <= tick_dly_d;
      key_q        <= key_d;
`ifdef KEY_STABLE_FILTER_EN
      key_prev_q   <= key_prev_d;
`endif
      left_q       <= left_d;
      right_q      <= right_d;
      down_q       <= down_d;
      state_q      <= state_d;
      jump_start_q <= jump_start_d;
      jump_hold_q  <= jump_hold_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign left       = left_q;
  assign right      = right_q;
  assign down       = down_q;
  assign jump_start = jump_start_q;
  assign jump_hold  = jump_hold_q;
  assign hold_cnt   = hold_cnt_q;

endmodule

// File: tb/tb_mario_input_ctrl.sv
// tb/tb_mario_input_ctrl.sv - directed scoreboard bench for mario_input_ctrl

module tb_mario_input_ctrl;

  localparam int MAX_HOLD = 12;

  logic       Clk;
  logic       Reset_n;
  logic       frame_vs;
  logic [7:0] keycode;
  logic       grounded;
  logic       frame_tick;
  logic       left;
  logic       right;
  logic       down;
  logic       jump_start;
  logic       jump_hold;
  logic [3:0] hold_cnt;

  mario_input_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_vs   (frame_vs),
    .keycode    (keycode),
    .grounded   (grounded),
    .frame_tick (frame_tick),
    .left       (left),
    .right      (right),
    .down       (down),
    .jump_start (jump_start),
    .jump_hold  (jump_hold),
    .hold_cnt   (hold_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       l;
    logic       r;
    logic       d;
    logic       js;
    logic       jh;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Frame-level reference model
  logic [7:0] m_key;
  logic [7:0] m_prev;
  int         m_state;  // 0 idle, 1 rise, 2 lock
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key   = 8'h00;
    m_prev  = 8'h00;
    m_state = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [7:0] k, input logic g, output exp_t e);
    logic jk;
    logic js;
`ifdef KEY_STABLE_FILTER_EN
    if (k == m_prev) m_key = k;
    m_prev = k;
`else
    m_key = k;
`endif
    jk = (m_key == 8'h1A);
    js = 1'b0;
    if (m_state == 0) begin
      if (jk && g) begin
        m_state = 1;
        m_cnt   = 0;
        js      = 1'b1;
      end
    end else if (m_state == 1) begin
      if (!jk || m_cnt == MAX_HOLD - 1) m_state = 2;
      else m_cnt = m_cnt + 1;
    end else begin
      if (!jk && g) begin
        m_state = 0;
        m_cnt   = 0;
      end
    end
    e.l   = (m_key == 8'h04);
    e.r   = (m_key == 8'h07);
    e.d   = (m_key == 8'h16);
    e.js  = js;
    e.jh  = (m_state == 1);
    e.cnt = 4'(m_cnt);
  endtask

  // One vsync pulse with the given key/grounded, then check the outputs at
  // their expected latencies after the raw rising edge.
  task automatic do_frame(input logic [7:0] k, input logic g);
    exp_t e;
    int   lat;
    @(negedge Clk);
    keycode  = k;
    grounded = g;
    frame_vs = 1'b0;
    repeat (4) @(negedge Clk);
    frame_vs = 1'b1;
    model_step(k, g, e);
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (frame_tick !== 1'b1 && lat < 10);
    chk("tick_latency", lat, 3);
    @(negedge Clk);
    e = exp_q.pop_front();
    chk("tick_width", frame_tick, 1'b0);
    chk("left", left, e.l);
    chk("right", right, e.r);
    chk("down", down, e.d);
    @(negedge Clk);
    chk("jump_start", jump_start, e.js);
    chk("jump_hold", jump_hold, e.jh);
    chk("hold_cnt", hold_cnt, e.cnt);
    @(negedge Clk);
    chk("jump_start_pulse", jump_start, 1'b0);
  endtask

  // Change the keycode between ticks: outputs must not move
  task automatic mid_change(input logic [7:0] k, input int cycles);
    logic l0, r0, d0;
    l0 = (m_key == 8'h04);
    r0 = (m_key == 8'h07);
    d0 = (m_key == 8'h16);
    @(negedge Clk);
    keycode = k;
    repeat (cycles) @(negedge Clk);
    chk("mid_left", left, l0);
    chk("mid_right", right, r0);
    chk("mid_down", down, d0);
    chk("mid_tick", frame_tick, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ticks;
    model_reset();
    Reset_n  = 1'b0;
    keycode  = 8'h04;
    grounded = 1'b0;
    frame_vs = 1'b1;

    // Reset with VS toggling: everything quiet
    repeat (3) begin
      @(negedge Clk);
      frame_vs = ~frame_vs;
      chk("rst_tick", frame_tick, 1'b0);
      chk("rst_dirs", {left, right, down}, 3'b000);
      chk("rst_jump", {jump_start, jump_hold}, 2'b00);
      chk("rst_cnt", hold_cnt, 4'h0);
    end
    @(negedge Clk);
    frame_vs = 1'b1;
    Reset_n  = 1'b1;
    ticks = 0;
    repeat (6) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) ticks++;
    end
    chk("post_rst_no_tick", ticks, 0);

    // Directions
    do_frame(8'h04, 1'b1);
    mid_change(8'h07, 6);
    do_frame(8'h07, 1'b1);
    do_frame(8'h16, 1'b1);
    do_frame(8'h00, 1'b1);
    do_frame(8'h55, 1'b1);

    // Short jump, then land
    repeat (3) do_frame(8'h1A, 1'b1);
    do_frame(8'h00, 1'b0);
    do_frame(8'h00, 1'b0);
    do_frame(8'h00, 1'b1);

    // Long hold saturates, no re-trigger while held
    repeat (20) do_frame(8'h1A, 1'b1);
    do_frame(8'h00, 1'b1);

    // Airborne press
    repeat (2) do_frame(8'h1A, 1'b0);
    do_frame(8'h00, 1'b1);

    // Mid-jump reset
    repeat (6) do_frame(8'h1A, 1'b1);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("midrst_hold", jump_hold, 1'b0);
    chk("midrst_cnt", hold_cnt, 4'h0);
    chk("midrst_dirs", {left, right, down}, 3'b000);
    model_reset();
    Reset_n = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("midrst_no_start", jump_start, 1'b0);
    end
    do_frame(8'h1A, 1'b1);
    do_frame(8'h00, 1'b1);
    do_frame(8'h00, 1'b1);

    // Single-frame glitch
    do_frame(8'h04, 1'b1);
    do_frame(8'h00, 1'b1);
    do_frame(8'h00, 1'b1);

    // VS frozen: no ticks, outputs hold
    do_frame(8'h07, 1'b1);
    do_frame(8'h07, 1'b1);
    @(negedge Clk);
    keycode = 8'h04;
    ticks = 0;
    repeat (30) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) ticks++;
    end
    chk("freeze_ticks", ticks, 0);
    chk("freeze_right", right, (m_key == 8'h07));
    chk("freeze_left", left, 1'b0);

    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
